// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stall, flush, forwarding and halt control for the in-order MIPS pipeline.
// Define HAZARD_STATS_EN to add saturating stall/flush/freeze event counters.
module pipeline_hazard_unit #(
  parameter int STAGES       = 3,
  parameter int REG_W        = 5,
  parameter int MEM_STAGE    = 2,
  parameter int BRANCH_STAGE = 2,
  parameter int LOAD_READY   = 3,
  parameter int STAT_W       = 32,
  localparam int SEL_W       = $clog2(STAGES + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wen,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_is_load,
  input  logic              id_is_mem,
  input  logic              id_halt,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_flush,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              halt
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt,
  output logic [STAT_W-1:0] freeze_cnt
`endif
);

  if (STAGES < 1 || MEM_STAGE < 1 || MEM_STAGE > STAGES || BRANCH_STAGE < 1 ||
      BRANCH_STAGE > STAGES || LOAD_READY < 1 || STAT_W < 1) begin : g_param_check
    $error("pipeline_hazard_unit: illegal parameter combination");
  end

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic [REG_W-1:0] dest;
    logic             is_load;
    logic             is_mem;
    logic             halt_op;
  } entry_t;

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_HALTED,
    MODE_FREEZE,
    MODE_BRANCH,
    MODE_STALL,
    MODE_IWAIT,
    MODE_RUN
  } mode_t;

  localparam logic [STAGES-1:0] BRANCH_MASK = STAGES'((1 << BRANCH_STAGE) - 1);

  entry_t           s [1:STAGES];
  entry_t           id_entry;
  logic             halt_r;
  logic             frozen;
  logic             load_use;
  logic             halt_fetch;
  logic [SEL_W-1:0] fwd_a_raw;
  logic [SEL_W-1:0] fwd_b_raw;
  mode_t            mode;

  // Producer in stage e writes the register the ID instruction actually reads.
  function automatic logic writes_src(input entry_t e, input logic [REG_W-1:0] src,
                                      input logic used);
    writes_src = e.valid && e.wen && (e.dest != '0) && (e.dest == src) && used;
  endfunction

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = id_valid;
    id_entry.wen     = id_wen;
    id_entry.dest    = id_dest;
    id_entry.is_load = id_is_load;
    id_entry.is_mem  = id_is_mem;
    id_entry.halt_op = id_halt;
  end

  assign frozen = s[MEM_STAGE].valid && s[MEM_STAGE].is_mem && !dhit;

  always_comb begin
    load_use   = 1'b0;
    halt_fetch = id_valid && id_halt;
    for (int k = 1; k <= STAGES; k++) begin
      if (k < LOAD_READY && s[k].is_load &&
          (writes_src(s[k], id_rs, id_uses_rs) || writes_src(s[k], id_rt, id_uses_rt)))
        load_use = 1'b1;
      if (s[k].valid && s[k].halt_op)
        halt_fetch = 1'b1;
    end
    load_use = load_use && id_valid;
  end

  // Walk from oldest to youngest so the youngest eligible producer wins.
  always_comb begin
    fwd_a_raw = '0;
    fwd_b_raw = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (writes_src(s[k], id_rs, id_uses_rs) && (!s[k].is_load || k >= LOAD_READY))
        fwd_a_raw = SEL_W'(k);
      if (writes_src(s[k], id_rt, id_uses_rt) && (!s[k].is_load || k >= LOAD_READY))
        fwd_b_raw = SEL_W'(k);
    end
  end

  always_comb begin
    if (RST)                    mode = MODE_RESET;
    else if (halt_r)            mode = MODE_HALTED;
    else if (frozen)            mode = MODE_FREEZE;
    else if (branch_taken)      mode = MODE_BRANCH;
    else if (load_use)          mode = MODE_STALL;
    else if (!ihit)             mode = MODE_IWAIT;
    else                        mode = MODE_RUN;
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    stage_en    = '0;
    stage_flush = '0;
    fwd_sel_a   = fwd_a_raw;
    fwd_sel_b   = fwd_b_raw;
    unique case (mode)
      MODE_RESET: begin
        ifid_flush  = 1'b1;
        stage_flush = '1;
        fwd_sel_a   = '0;
        fwd_sel_b   = '0;
      end
      MODE_HALTED: begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
      end
      MODE_FREEZE: begin
      end
      MODE_BRANCH: begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        stage_en    = '1;
        stage_flush = BRANCH_MASK;
      end
      MODE_STALL: begin
        stage_en       = '1;
        stage_flush[0] = 1'b1;
      end
      MODE_IWAIT: begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        stage_en   = '1;
      end
      MODE_RUN: begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        stage_en = '1;
      end
      default: begin
      end
    endcase
    // A halt anywhere past fetch stops fetching; a load-use stall keeps IF/ID held instead.
    if (halt_fetch && (mode inside {MODE_BRANCH, MODE_IWAIT, MODE_RUN})) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_r <= 1'b0;
      for (int k = 1; k <= STAGES; k++)
        s[k] <= '0;
    end else begin
      if (mode != MODE_FREEZE && s[STAGES].valid && s[STAGES].halt_op)
        halt_r <= 1'b1;
      if (stage_en[0])
        s[1] <= stage_flush[0] ? '0 : id_entry;
      for (int k = 2; k <= STAGES; k++)
        if (stage_en[k-1])
          s[k] <= stage_flush[k-1] ? '0 : s[k-1];
    end
  end

  assign halt = halt_r;

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (mode == MODE_STALL && stall_cnt != STAT_MAX)
        stall_cnt <= stall_cnt + STAT_W'(1);
      if (mode == MODE_BRANCH && flush_cnt != STAT_MAX)
        flush_cnt <= flush_cnt + STAT_W'(1);
      if (mode == MODE_FREEZE && freeze_cnt != STAT_MAX)
        freeze_cnt <= freeze_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed plus randomized stimulus, scored against a queue-based
// model of the post-decode pipeline.
`timescale 1ns/1ps
module tb_pipeline_hazard_unit;
  localparam int STAGES       = 3;
  localparam int REG_W        = 5;
  localparam int MEM_STAGE    = 2;
  localparam int BRANCH_STAGE = 2;
  localparam int LOAD_READY   = 3;
  localparam int STAT_W       = 32;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              ihit = 1'b1, dhit = 1'b1, id_valid = 1'b0;
  logic [REG_W-1:0]  id_rs = '0, id_rt = '0, id_dest = '0;
  logic              id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_wen = 1'b0;
  logic              id_is_load = 1'b0, id_is_mem = 1'b0, id_halt = 1'b0;
  logic              branch_taken = 1'b0;
  logic              pc_en, ifid_en, ifid_flush, halt;
  logic [STAGES-1:0] stage_en, stage_flush;
  logic [1:0]        fwd_sel_a, fwd_sel_b;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  pipeline_hazard_unit #(
    .STAGES(STAGES), .REG_W(REG_W), .MEM_STAGE(MEM_STAGE),
    .BRANCH_STAGE(BRANCH_STAGE), .LOAD_READY(LOAD_READY), .STAT_W(STAT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wen(id_wen), .id_dest(id_dest), .id_is_load(id_is_load), .id_is_mem(id_is_mem),
    .id_halt(id_halt), .branch_taken(branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .stage_en(stage_en), .stage_flush(stage_flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .halt(halt)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit             valid, wen, is_load, is_mem, halt_op;
    bit [REG_W-1:0] dest;
  } instr_t;

  typedef struct {
    bit             rst, ihit, dhit, id_valid, uses_rs, uses_rt, wen;
    bit             is_load, is_mem, id_halt, branch;
    bit [REG_W-1:0] rs, rt, dest;
  } stim_t;

  typedef struct {
    bit              pc_en, ifid_en, ifid_flush, halt;
    bit [STAGES-1:0] stage_en, stage_flush;
    bit [1:0]        fa, fb;
    int              cyc;
  } exp_t;

  typedef enum {A_RESET, A_HALTED, A_FREEZE, A_BRANCH, A_STALL, A_IWAIT, A_RUN} act_t;

  instr_t pipe[$];     // pipe[0] is stage 1 (EX), pipe[STAGES-1] is the oldest
  bit     ref_halt;
  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  function automatic bit [1:0] ref_fwd(bit [REG_W-1:0] r, bit used);
    if (!used || r == 0) return 2'd0;
    foreach (pipe[i])
      if (pipe[i].valid && pipe[i].wen && pipe[i].dest == r &&
          (!pipe[i].is_load || i + 1 >= LOAD_READY))
        return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic bit ref_load_use(stim_t st);
    if (!st.id_valid) return 1'b0;
    for (int i = 0; i < LOAD_READY - 1 && i < pipe.size(); i++)
      if (pipe[i].valid && pipe[i].is_load && pipe[i].wen && pipe[i].dest != 0 &&
          ((st.uses_rs && pipe[i].dest == st.rs) || (st.uses_rt && pipe[i].dest == st.rt)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ref_halt_fetch(stim_t st);
    if (st.id_valid && st.id_halt) return 1'b1;
    foreach (pipe[i]) if (pipe[i].valid && pipe[i].halt_op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic act_t decide(stim_t st);
    if (st.rst) return A_RESET;
    if (ref_halt) return A_HALTED;
    if (pipe[MEM_STAGE-1].valid && pipe[MEM_STAGE-1].is_mem && !st.dhit) return A_FREEZE;
    if (st.branch) return A_BRANCH;
    if (ref_load_use(st)) return A_STALL;
    if (!st.ihit) return A_IWAIT;
    return A_RUN;
  endfunction

  function automatic exp_t expect_for(stim_t st, act_t act);
    exp_t e;
    e = '{default: 0};
    e.cyc  = cyc;
    e.halt = ref_halt;
    if (act != A_RESET && act != A_HALTED) begin
      e.fa = ref_fwd(st.rs, st.uses_rs);
      e.fb = ref_fwd(st.rt, st.uses_rt);
    end
    case (act)
      A_RESET:  begin e.ifid_flush = 1; e.stage_flush = '1; end
      A_BRANCH: begin
        e.pc_en = 1; e.ifid_en = 1; e.ifid_flush = 1; e.stage_en = '1;
        for (int k = 1; k <= STAGES; k++) e.stage_flush[k-1] = (k <= BRANCH_STAGE);
      end
      A_STALL:  begin e.stage_en = '1; e.stage_flush[0] = 1; end
      A_IWAIT:  begin e.ifid_en = 1; e.ifid_flush = 1; e.stage_en = '1; end
      A_RUN:    begin e.pc_en = 1; e.ifid_en = 1; e.stage_en = '1; end
      default:  ;
    endcase
    if (ref_halt_fetch(st) && (act == A_BRANCH || act == A_IWAIT || act == A_RUN)) begin
      e.pc_en = 0;
      e.ifid_flush = 1;
    end
    return e;
  endfunction

  task automatic model_step(stim_t st, act_t act);
    instr_t ni;
    int     nf;
    case (act)
      A_RESET: begin
        foreach (pipe[i]) pipe[i].valid = 0;
        ref_halt = 0;
      end
      A_HALTED, A_FREEZE: ;
      default: begin
        if (pipe[STAGES-1].valid && pipe[STAGES-1].halt_op) ref_halt = 1;
        ni = '{valid: st.id_valid, wen: st.wen, is_load: st.is_load, is_mem: st.is_mem,
               halt_op: st.id_halt, dest: st.dest};
        pipe.push_front(ni);
        void'(pipe.pop_back());
        nf = (act == A_BRANCH) ? BRANCH_STAGE : (act == A_STALL) ? 1 : 0;
        for (int i = 0; i < nf; i++) pipe[i].valid = 0;
      end
    endcase
  endtask

  task automatic apply_stimulus(stim_t st);
    act_t act;
    RST = st.rst; ihit = st.ihit; dhit = st.dhit; id_valid = st.id_valid;
    id_rs = st.rs; id_rt = st.rt; id_uses_rs = st.uses_rs; id_uses_rt = st.uses_rt;
    id_wen = st.wen; id_dest = st.dest; id_is_load = st.is_load; id_is_mem = st.is_mem;
    id_halt = st.id_halt; branch_taken = st.branch;
    act = decide(st);
    exp_q.push_back(expect_for(st, act));
    @(posedge CLK);
    model_step(st, act);
    cyc++;
    #1;
  endtask

  task automatic check_field(string name, int c, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, c, got, want);
    end
  endtask

  task automatic check_output(exp_t e);
    check_field("pc_en", e.cyc, 8'(pc_en), 8'(e.pc_en));
    check_field("ifid_en", e.cyc, 8'(ifid_en), 8'(e.ifid_en));
    check_field("ifid_flush", e.cyc, 8'(ifid_flush), 8'(e.ifid_flush));
    check_field("stage_en", e.cyc, 8'(stage_en), 8'(e.stage_en));
    check_field("stage_flush", e.cyc, 8'(stage_flush), 8'(e.stage_flush));
    check_field("fwd_sel_a", e.cyc, 8'(fwd_sel_a), 8'(e.fa));
    check_field("fwd_sel_b", e.cyc, 8'(fwd_sel_b), 8'(e.fb));
    check_field("halt", e.cyc, 8'(halt), 8'(e.halt));
  endtask

  function automatic stim_t idle();
    stim_t st;
    st = '{default: 0};
    st.ihit = 1;
    st.dhit = 1;
    return st;
  endfunction

  function automatic stim_t alu(int rd, int rs, int rt);
    stim_t st;
    st = idle();
    st.id_valid = 1; st.wen = 1; st.uses_rs = 1; st.uses_rt = 1;
    st.dest = REG_W'(rd); st.rs = REG_W'(rs); st.rt = REG_W'(rt);
    return st;
  endfunction

  function automatic stim_t lw(int rd, int base);
    stim_t st;
    st = alu(rd, base, 0);
    st.uses_rt = 0; st.is_load = 1; st.is_mem = 1;
    return st;
  endfunction

  function automatic stim_t sw(int base, int rt);
    stim_t st;
    st = alu(0, base, rt);
    st.wen = 0; st.is_mem = 1;
    return st;
  endfunction

  function automatic stim_t random_stim();
    stim_t st;
    int    kind;
    kind = $urandom_range(0, 9);
    if (kind < 5)      st = alu($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
    else if (kind < 7) st = lw($urandom_range(0, 5), $urandom_range(0, 5));
    else if (kind < 8) st = sw($urandom_range(0, 5), $urandom_range(0, 5));
    else begin
      st = alu(0, $urandom_range(0, 5), $urandom_range(0, 5));
      st.wen = 0;
    end
    st.id_valid = ($urandom_range(0, 9) < 8);
    st.id_halt  = ($urandom_range(0, 149) == 0);
    st.ihit     = ($urandom_range(0, 9) < 8);
    st.dhit     = ($urandom_range(0, 9) < 7);
    st.branch   = ($urandom_range(0, 9) == 0);
    st.rst      = ref_halt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 199) == 0);
    return st;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    stim_t st;
    repeat (STAGES) pipe.push_back('{default: 0});
    ref_halt = 0;
    @(posedge CLK);
    #1;
    st = idle(); st.rst = 1;
    repeat (2) apply_stimulus(st);
    apply_stimulus(idle());
    // forwarding from EX and MEM, and $0 never forwarding
    apply_stimulus(alu(3, 1, 2));
    apply_stimulus(alu(6, 3, 4));
    apply_stimulus(alu(7, 8, 3));
    apply_stimulus(alu(0, 1, 2));
    apply_stimulus(alu(9, 0, 0));
    // load-use: two stall cycles then forward from WB
    apply_stimulus(lw(5, 1));
    st = alu(10, 2, 5);
    repeat (3) apply_stimulus(st);
    // taken branch with stage 2 valid
    apply_stimulus(alu(11, 1, 1));
    st = alu(12, 1, 1); st.branch = 1;
    apply_stimulus(st);
    apply_stimulus(idle());
    // sw freezes the pipe in MEM; branch during freeze is deferred
    apply_stimulus(sw(1, 2));
    apply_stimulus(idle());
    st = idle(); st.dhit = 0;
    apply_stimulus(st);
    st.branch = 1;
    repeat (2) apply_stimulus(st);
    st.dhit = 1;
    apply_stimulus(st);
    apply_stimulus(idle());
    // halt drains through the pipe and sticks until reset
    st = idle(); st.id_valid = 1; st.id_halt = 1;
    apply_stimulus(st);
    for (int i = 0; i < 8; i++) begin
      st = idle(); st.ihit = i[0]; st.dhit = i[1];
      apply_stimulus(st);
    end
    st = idle(); st.rst = 1;
    apply_stimulus(st);
    apply_stimulus(idle());
    $display("[TB] directed phase done, starting random phase");
    for (int n = 0; n < 3000; n++) apply_stimulus(random_stim());
    repeat (2) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
